execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL: clk  input  1  clock; all state rising-edge.
REQ-002 SHALL: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: operand1, operand2  input  32 each  source operands from decode.
REQ-004 SHALL: alu_operation  input  5  ALU_constants code (ADDITION, SUBTRACTION, MULTIPLICATION, UNCOND_JUMP, COND_EQ_JUMP).
REQ-005 SHALL: dest_register_enable  input  1; dest_register_number  input  5  writeback target from decode.
REQ-006 SHALL: next_program_counter  input  32  PC+4 of the instruction (link value).
REQ-007 SHALL: branch_dest  input  32  precomputed PC-relative branch target.
REQ-008 SHALL: result  output  32  registered ALU/link result.
REQ-009 SHALL: out_dest_register_enable  output  1; out_dest_register_number  output  5  registered writeback control.
REQ-010 SHALL: branch_taken  output  1  registered one-cycle redirect pulse; drives fetch redirect and decode kill_instr.
REQ-011 SHALL: branch_target  output  32  registered redirect address, valid while branch_taken=1.
REQ-012 SHALL: stall  output  1  combinational; upstream holds its outputs at any edge where stall=1.

Function
REQ-013 SHALL: all ops except iterative MUL: 1-cycle latency, inputs in cycle N -> outputs registered at end of N.
REQ-014 SHALL: ADDITION: result=(operand1+operand2) mod 2^32; unknown codes behave as ADDITION.
REQ-015 SHALL: SUBTRACTION: result=(operand1-operand2) mod 2^32.
REQ-016 SHALL: MULTIPLICATION: result = low 32 bits of unsigned product.
REQ-017 SHALL: UNCOND_JUMP: branch_taken=1, branch_target=(operand1+operand2)&~1, result=next_program_counter, dest control passed through.
REQ-018 SHALL: COND_EQ_JUMP: branch_taken=(operand1==operand2), branch_target=branch_dest, result=0, out_dest_register_enable=0.
REQ-019 SHALL: non-branch ops: branch_taken=0, branch_target holds previous value; dest control passed through unchanged (x0 included).
REQ-020 SHALL: squash: inputs in any cycle where branch_taken=1 are wrong-path -> out_dest_register_enable=0, branch_taken=0, no MUL start, stall=0.
REQ-021 SHALL: iterative MUL FSM states IDLE, BUSY; 5-bit count; shift-add one multiplier bit per BUSY cycle.
REQ-022 SHALL: IDLE + MULTIPLICATION + not squashed in cycle 0 -> latch operands, count=0, go BUSY at end of cycle 0.
REQ-023 SHALL: stall = (IDLE & MUL & not squashed) | (BUSY & count!=31); high cycles 0..31, low cycle 32.
REQ-024 SHALL: BUSY with count==31 (cycle 32): write result and dest control at end of cycle, return to IDLE; inputs ignored while BUSY.
REQ-025 SHALL: during BUSY cycles 1..31 out_dest_register_enable=0 and branch_taken=0 (bubble).

Reset
REQ-026 SHALL: reset -> result=0, out_dest_register_enable=0, out_dest_register_number=0, branch_taken=0, branch_target=0, FSM=IDLE, count=0.
REQ-027 SHALL: stall forced 0 while reset=1; reset mid-multiply abandons it, no partial result written.

Configuration
REQ-028 SHALL: macro EXEC_ITER_MUL_EN defined -> iterative 33-cycle MUL per REQ-021..025.
REQ-029 SHALL: EXEC_ITER_MUL_EN undefined -> single-cycle combinational MUL, FSM absent, stall tied 0.

Verification
REQ-030 SHALL: ADDITION 5,7, dest en x3 -> next cycle result=12, enable=1, number=3.
REQ-031 SHALL: SUBTRACTION 0,1 -> result=0xFFFFFFFF; ADDITION 0xFFFFFFFF,1 -> result=0.
REQ-032 SHALL: MULTIPLICATION 0xFFFF,0x10001 x5 (macro on) -> stall=1 for 32 cycles, enable=0 meanwhile, result=0xFFFFFFFF enable=1 after cycle 32; macro off -> same result next cycle, stall=0.
REQ-033 SHALL: COND_EQ_JUMP 9,9 branch_dest=0x100 -> branch_taken=1 one cycle, target=0x100; following ADD x4 squashed (enable=0); with 9,8 -> branch_taken=0.
REQ-034 SHALL: UNCOND_JUMP 0x203,4 next_pc=0x24 x1 -> branch_taken=1, target=0x206, result=0x24, enable=1, number=1.
REQ-035 SHALL: reset pulse at BUSY cycle 10 -> all outputs 0, stall=0; subsequent MUL takes full 33 cycles with correct result.

Source files
------------

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ALU/branch execute stage with optional iterative multiplier.
// Define EXEC_ITER_MUL_EN for the 33-cycle shift-add MUL; otherwise MUL is single-cycle.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [4:0]  alu_operation,
  input  logic        dest_register_enable,
  input  logic [4:0]  dest_register_number,
  input  logic [31:0] next_program_counter,
  input  logic [31:0] branch_dest,
  output logic [31:0] result,
  output logic        out_dest_register_enable,
  output logic [4:0]  out_dest_register_number,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall
);

  localparam logic [4:0] ADDITION       = 5'd0;
  localparam logic [4:0] SUBTRACTION    = 5'd1;
  localparam logic [4:0] MULTIPLICATION = 5'd2;
  localparam logic [4:0] UNCOND_JUMP    = 5'd3;
  localparam logic [4:0] COND_EQ_JUMP   = 5'd4;

  logic [31:0] result_q, result_d;
  logic        dest_en_q, dest_en_d;
  logic [4:0]  dest_num_q, dest_num_d;
  logic        branch_taken_q, branch_taken_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic [31:0] sum;
  logic        squash;

  assign sum    = operand1 + operand2;
  // The instruction behind a taken branch is wrong-path and must not retire.
  assign squash = branch_taken_q;

`ifdef EXEC_ITER_MUL_EN
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        mul_en_q, mul_en_d;
  logic [4:0]  mul_num_q, mul_num_d;
  logic [31:0] acc_sum;
  logic        mul_start;

  assign mul_start = (state_q == IDLE) && (alu_operation == MULTIPLICATION) && !squash;
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  assign stall     = !reset && (mul_start || ((state_q == BUSY) && (count_q != 5'd31)));
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    result_d        = sum;
    dest_en_d       = dest_register_enable;
    dest_num_d      = dest_register_number;
    branch_taken_d  = 1'b0;
    branch_target_d = branch_target_q;
    case (alu_operation)
      SUBTRACTION: result_d = operand1 - operand2;
`ifndef EXEC_ITER_MUL_EN
      MULTIPLICATION: result_d = operand1 * operand2;
`endif
      UNCOND_JUMP: begin
        result_d        = next_program_counter;
        branch_taken_d  = 1'b1;
        branch_target_d = sum & ~32'd1;
      end
      COND_EQ_JUMP: begin
        result_d        = 32'd0;
        dest_en_d       = 1'b0;
        branch_taken_d  = (operand1 == operand2);
        branch_target_d = branch_dest;
      end
      default: result_d = sum;
    endcase
    if (squash) begin
      result_d        = result_q;
      dest_en_d       = 1'b0;
      branch_taken_d  = 1'b0;
      branch_target_d = branch_target_q;
    end
`ifdef EXEC_ITER_MUL_EN
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mul_en_d  = mul_en_q;
    mul_num_d = mul_num_q;
    if (state_q == BUSY) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 5'd1;
      branch_taken_d  = 1'b0;
      branch_target_d = branch_target_q;
      if (count_q == 5'd31) begin
        result_d   = acc_sum;
        dest_en_d  = mul_en_q;
        dest_num_d = mul_num_q;
        state_d    = IDLE;
        count_d    = 5'd0;
      end else begin
        result_d   = result_q;
        dest_en_d  = 1'b0;
        dest_num_d = dest_num_q;
      end
    end else if (mul_start) begin
      // Cycle 0 latches everything; the held upstream inputs are ignored afterwards.
      state_d    = BUSY;
      count_d    = 5'd0;
      acc_d      = 32'd0;
      mcand_d    = operand1;
      mplier_d   = operand2;
      mul_en_d   = dest_register_enable;
      mul_num_d  = dest_register_number;
      result_d   = result_q;
      dest_en_d  = 1'b0;
      dest_num_d = dest_num_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q        <= 32'd0;
      dest_en_q       <= 1'b0;
      dest_num_q      <= 5'd0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= 32'd0;
    end else begin
      result_q        <= result_d;
      dest_en_q       <= dest_en_d;
      dest_num_q      <= dest_num_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

`ifdef EXEC_ITER_MUL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      acc_q     <= 32'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      mul_en_q  <= 1'b0;
      mul_num_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      mul_en_q  <= mul_en_d;
      mul_num_q <= mul_num_d;
    end
  end
`endif

  assign result                   = result_q;
  assign out_dest_register_enable = dest_en_q;
  assign out_dest_register_number = dest_num_q;
  assign branch_taken             = branch_taken_q;
  assign branch_target            = branch_target_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against an instruction-level model.
module tb_execute_stage;

  localparam logic [4:0] ADDITION       = 5'd0;
  localparam logic [4:0] SUBTRACTION    = 5'd1;
  localparam logic [4:0] MULTIPLICATION = 5'd2;
  localparam logic [4:0] UNCOND_JUMP    = 5'd3;
  localparam logic [4:0] COND_EQ_JUMP   = 5'd4;
`ifdef EXEC_ITER_MUL_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic        clk, reset;
  logic [31:0] operand1, operand2, next_program_counter, branch_dest;
  logic [4:0]  alu_operation, dest_register_number;
  logic        dest_register_enable;
  logic [31:0] result, branch_target;
  logic        out_dest_register_enable, branch_taken, stall;
  logic [4:0]  out_dest_register_number;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .operand1(operand1), .operand2(operand2), .alu_operation(alu_operation),
    .dest_register_enable(dest_register_enable), .dest_register_number(dest_register_number),
    .next_program_counter(next_program_counter), .branch_dest(branch_dest),
    .result(result), .out_dest_register_enable(out_dest_register_enable),
    .out_dest_register_number(out_dest_register_number),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instruction-level model: expected registered outputs plus multiply progress.
  logic [31:0] m_res, m_tgt, m_prod;
  logic        m_en, m_bt, m_men;
  logic [4:0]  m_num, m_mnum;
  logic        m_chk_res, m_chk_num;
  int          m_mulk;
  logic        last_stall;
  int          stall_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_res = 0; m_tgt = 0; m_en = 0; m_bt = 0; m_num = 0;
    m_mulk = 0; m_chk_res = 1; m_chk_num = 1;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    logic exp_stall;
    logic [31:0] a, b;
    a = operand1; b = operand2;
    #1;
    exp_stall = 1'b0;
    if (ITER && m_mulk > 0) exp_stall = (m_mulk != 32);
    else if (ITER && alu_operation == MULTIPLICATION && !m_bt) exp_stall = 1'b1;
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    last_stall = stall;
    if (stall) stall_cnt++;
    m_chk_res = 1; m_chk_num = 1;
    if (ITER && m_mulk > 0) begin
      if (m_mulk == 32) begin
        m_res = m_prod; m_en = m_men; m_num = m_mnum; m_bt = 0; m_mulk = 0;
      end else begin
        m_en = 0; m_bt = 0; m_chk_res = 0; m_chk_num = 0; m_mulk++;
      end
    end else if (m_bt) begin
      m_en = 0; m_bt = 0; m_chk_res = 0; m_chk_num = 0;
    end else if (ITER && alu_operation == MULTIPLICATION) begin
      m_prod = a * b; m_men = dest_register_enable; m_mnum = dest_register_number;
      m_mulk = 1; m_en = 0; m_bt = 0; m_chk_res = 0; m_chk_num = 0;
    end else begin
      m_en = dest_register_enable; m_num = dest_register_number; m_bt = 0;
      case (alu_operation)
        SUBTRACTION:    m_res = a - b;
        MULTIPLICATION: m_res = a * b;
        UNCOND_JUMP: begin m_res = next_program_counter; m_bt = 1; m_tgt = (a + b) & ~32'd1; end
        COND_EQ_JUMP: begin m_res = 0; m_en = 0; m_bt = (a == b); m_tgt = branch_dest; end
        default:        m_res = a + b;
      endcase
    end
    @(posedge clk); #1;
    chk("enable", {31'd0, out_dest_register_enable}, {31'd0, m_en});
    chk("branch_taken", {31'd0, branch_taken}, {31'd0, m_bt});
    chk("branch_target", branch_target, m_tgt);
    if (m_chk_res) chk("result", result, m_res);
    if (m_chk_num) chk("number", {27'd0, out_dest_register_number}, {27'd0, m_num});
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic [4:0] num,
                       input logic [31:0] npc, input logic [31:0] bd);
    alu_operation = op; operand1 = a; operand2 = b;
    dest_register_enable = en; dest_register_number = num;
    next_program_counter = npc; branch_dest = bd;
  endtask

  // Presents one instruction and holds it while the stage stalls.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic [4:0] num,
                       input logic [31:0] npc, input logic [31:0] bd);
    int guard;
    drive(op, a, b, en, num, npc, bd);
    guard = 0;
    stall_cnt = 0;
    do begin
      cycle();
      guard++;
    end while (last_stall && guard < 40);
    if (last_stall) begin
      errors++; checks++;
      $display("FAIL issue_timeout: stall still 1 after %0d cycles, expected release", guard);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(ADDITION, 0, 0, 0, 0, 0, 0);
    model_reset();
    last_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_enable", {31'd0, out_dest_register_enable}, 32'd0);
    chk("reset_number", {27'd0, out_dest_register_number}, 32'd0);
    chk("reset_branch_taken", {31'd0, branch_taken}, 32'd0);
    chk("reset_branch_target", branch_target, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    issue(ADDITION, 5, 7, 1, 3, 0, 0);
    chk("add_5_7", result, 32'd12);
    chk("add_en", {31'd0, out_dest_register_enable}, 32'd1);
    chk("add_num", {27'd0, out_dest_register_number}, 32'd3);
    issue(SUBTRACTION, 0, 1, 1, 2, 0, 0);
    chk("sub_wrap", result, 32'hFFFF_FFFF);
    issue(ADDITION, 32'hFFFF_FFFF, 1, 1, 2, 0, 0);
    chk("add_wrap", result, 32'd0);

    issue(MULTIPLICATION, 32'hFFFF, 32'h10001, 1, 5, 0, 0);
    chk("mul_result", result, 32'hFFFF_FFFF);
    chk("mul_en", {31'd0, out_dest_register_enable}, 32'd1);
    chk("mul_num", {27'd0, out_dest_register_number}, 32'd5);
    chk("mul_stall_cycles", stall_cnt, ITER ? 32'd32 : 32'd0);

    issue(COND_EQ_JUMP, 9, 9, 1, 7, 0, 32'h100);
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);
    chk("beq_target", branch_target, 32'h100);
    issue(ADDITION, 1, 1, 1, 4, 0, 0);
    chk("squash_en", {31'd0, out_dest_register_enable}, 32'd0);
    chk("squash_bt", {31'd0, branch_taken}, 32'd0);
    issue(COND_EQ_JUMP, 9, 8, 1, 7, 0, 32'h200);
    chk("bne_not_taken", {31'd0, branch_taken}, 32'd0);

    issue(UNCOND_JUMP, 32'h203, 4, 1, 1, 32'h24, 0);
    chk("jmp_taken", {31'd0, branch_taken}, 32'd1);
    chk("jmp_target", branch_target, 32'h206);
    chk("jmp_link", result, 32'h24);
    chk("jmp_en", {31'd0, out_dest_register_enable}, 32'd1);
    chk("jmp_num", {27'd0, out_dest_register_number}, 32'd1);
    issue(ADDITION, 3, 3, 1, 6, 0, 0);

    // Reset arriving in the middle of a multiply.
    drive(MULTIPLICATION, 32'd1234, 32'd5678, 1, 9, 0, 0);
    repeat (10) cycle();
    reset = 1'b1;
    #1;
    chk("midreset_result", result, 32'd0);
    chk("midreset_enable", {31'd0, out_dest_register_enable}, 32'd0);
    chk("midreset_number", {27'd0, out_dest_register_number}, 32'd0);
    chk("midreset_bt", {31'd0, branch_taken}, 32'd0);
    chk("midreset_target", branch_target, 32'd0);
    chk("midreset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    issue(MULTIPLICATION, 32'hFFFF, 32'h10001, 1, 5, 0, 0);
    chk("mul2_result", result, 32'hFFFF_FFFF);
    chk("mul2_stall_cycles", stall_cnt, ITER ? 32'd32 : 32'd0);

    // Random instruction stream; upstream holds its inputs whenever stall was high.
    last_stall = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        logic [4:0] op;
        logic [31:0] a, b;
        op = 5'($urandom_range(0, 9));
        if (op > 5'd7) op = ($urandom_range(0, 3) == 0) ? MULTIPLICATION : COND_EQ_JUMP;
        a = $urandom; b = $urandom;
        if ($urandom_range(0, 2) == 0) b = a;
        if ($urandom_range(0, 3) == 0) begin a = a & 32'hFF; b = b & 32'hFF; end
        drive(op, a, b, 1'($urandom), 5'($urandom), $urandom, $urandom);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
